// File: rtl/vx_mem_req_scheduler_if.sv
// Bundle between the requesters, the scheduler and the memory port.
// slave: scheduler side (requests in, memory request out, responses routed back).
// master: environment side (drives requests and memory responses).
interface vx_mem_req_scheduler_if #(
    parameter int NUM_REQS     = 2,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 8
);
    localparam int IDX_W         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0;
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W;
    localparam int BE_W          = DATA_WIDTH / 8;

    logic [NUM_REQS-1:0]              req_valid;
    logic [NUM_REQS-1:0]              req_rw;
    logic [NUM_REQS*BE_W-1:0]         req_byteen;
    logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQS*DATA_WIDTH-1:0]   req_data;
    logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag;
    logic [NUM_REQS-1:0]              req_ready;

    logic [NUM_REQS-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic [TAG_IN_WIDTH-1:0]          rsp_tag;
    logic [NUM_REQS-1:0]              rsp_ready;

    logic                             mem_req_valid;
    logic                             mem_req_rw;
    logic [BE_W-1:0]                  mem_req_byteen;
    logic [ADDR_WIDTH-1:0]            mem_req_addr;
    logic [DATA_WIDTH-1:0]            mem_req_data;
    logic [TAG_OUT_WIDTH-1:0]         mem_req_tag;
    logic                             mem_req_ready;

    logic                             mem_rsp_valid;
    logic [DATA_WIDTH-1:0]            mem_rsp_data;
    logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag;
    logic                             mem_rsp_ready;

    modport slave (
        input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        input  rsp_ready, mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output req_ready, rsp_valid, rsp_data, rsp_tag,
        output mem_req_valid, mem_req_rw, mem_req_byteen,
        output mem_req_addr, mem_req_data, mem_req_tag,
        output mem_rsp_ready
    );

    modport master (
        output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        output rsp_ready, mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_tag,
        input  mem_req_valid, mem_req_rw, mem_req_byteen,
        input  mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_req_scheduler.sv
// Round-robin scheduler sharing one memory port among NUM_REQS requesters,
// with per-requester read credits and requester index appended to the tag.
// Ports: clk, reset (async, active-high), bus (slave modport), busy.
// Optional MEM_SCHED_PERF_EN adds perf_stall_cycles / perf_reads counters.
module vx_mem_req_scheduler #(
    parameter int NUM_REQS     = 2,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 8,
    parameter int MAX_PENDING  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    vx_mem_req_scheduler_if.slave       bus,
`ifdef MEM_SCHED_PERF_EN
    output logic [31:0]                 perf_stall_cycles,
    output logic [31:0]                 perf_reads,
`endif
    output logic                        busy
);
    localparam int IDX_W         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0;
    localparam int PTR_W         = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W;
    localparam int BE_W          = DATA_WIDTH / 8;
    localparam int PEND_W        = $clog2(MAX_PENDING) + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [PEND_W-1:0]        pend_q [NUM_REQS];
    logic [PEND_W-1:0]        pend_d [NUM_REQS];
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [NUM_REQS-1:0]      elig, rsp_vld, rsp_fire;
    logic                     can_load, gnt_found, accept, acc_rd;
    logic [PTR_W-1:0]         gnt, rsp_idx;
    logic                     idx_ok;
    logic [TAG_OUT_WIDTH-1:0] tag_sel;
    int                       k;

    logic                     vld_q, rw_q;
    logic [BE_W-1:0]          be_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [TAG_OUT_WIDTH-1:0] tag_q;

    // A full read-credit pool masks reads only; writes always compete.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            elig[i] = bus.req_valid[i] &&
                      !(!bus.req_rw[i] && pend_q[i] == PEND_MAX);
        end
    end

    assign can_load = !vld_q || bus.mem_req_ready;

    // First eligible requester at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        k         = 0;
        for (int j = 0; j < NUM_REQS; j++) begin
            k = int'(ptr_q) + j;
            if (k >= NUM_REQS) k = k - NUM_REQS;
            if (!gnt_found && elig[k]) begin
                gnt_found = 1'b1;
                gnt       = PTR_W'(k);
            end
        end
    end

    assign accept        = can_load && gnt_found;
    assign acc_rd        = accept && !bus.req_rw[gnt];
    assign bus.req_ready = accept ? (NUM_REQS'(1) << gnt) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (int'(gnt) == NUM_REQS - 1) ? '0 : gnt + PTR_W'(1);
        end
    end

    generate
        if (IDX_W > 0) begin : g_idx
            assign tag_sel = {bus.req_tag[int'(gnt)*TAG_IN_WIDTH +: TAG_IN_WIDTH],
                              gnt[IDX_W-1:0]};
            assign rsp_idx = bus.mem_rsp_tag[IDX_W-1:0];
        end else begin : g_noidx
            assign tag_sel = bus.req_tag[TAG_IN_WIDTH-1:0];
            assign rsp_idx = '0;
        end
    endgenerate

    // Index codes beyond NUM_REQS exist only for non-power-of-2 counts;
    // such responses are consumed and dropped.
    assign idx_ok = (int'(rsp_idx) < NUM_REQS);

    always_comb begin
        rsp_vld = '0;
        if (bus.mem_rsp_valid && idx_ok) rsp_vld[rsp_idx] = 1'b1;
    end

    assign bus.rsp_valid     = rsp_vld;
    assign bus.rsp_data      = bus.mem_rsp_data;
    assign bus.rsp_tag       = bus.mem_rsp_tag[TAG_OUT_WIDTH-1 -: TAG_IN_WIDTH];
    assign bus.mem_rsp_ready = idx_ok ? bus.rsp_ready[rsp_idx] : 1'b1;
    assign rsp_fire          = rsp_vld & bus.rsp_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            pend_d[i] = pend_q[i];
            if (acc_rd && gnt == PTR_W'(i) && !rsp_fire[i]) begin
                pend_d[i] = pend_q[i] + PEND_W'(1);
            end else if (!(acc_rd && gnt == PTR_W'(i)) && rsp_fire[i]) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            rw_q   <= 1'b0;
            be_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
            for (int i = 0; i < NUM_REQS; i++) pend_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < NUM_REQS; i++) pend_q[i] <= pend_d[i];
            if (can_load) begin
                vld_q <= gnt_found;
                if (gnt_found) begin
                    rw_q   <= bus.req_rw[gnt];
                    be_q   <= bus.req_byteen[int'(gnt)*BE_W +: BE_W];
                    addr_q <= bus.req_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
                    data_q <= bus.req_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
                    tag_q  <= tag_sel;
                end
            end
        end
    end

    assign bus.mem_req_valid  = vld_q;
    assign bus.mem_req_rw     = rw_q;
    assign bus.mem_req_byteen = be_q;
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_data   = data_q;
    assign bus.mem_req_tag    = tag_q;

    always_comb begin
        busy = vld_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (pend_q[i] != '0) busy = 1'b1;
        end
    end

`ifdef MEM_SCHED_PERF_EN
    logic [31:0] stall_q, reads_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            reads_q <= '0;
        end else begin
            if (vld_q && !bus.mem_req_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
            if (acc_rd && !(&reads_q)) reads_q <= reads_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_reads        = reads_q;
`endif

    always @(posedge clk) begin
        if (!reset && bus.mem_rsp_valid) begin
            assert (idx_ok)
            else $error("mem_rsp_tag index out of range, response dropped");
        end
    end
endmodule
